// File: rtl/wb_stage_if.sv
// ---------------------------------------------------------------------------
// wb_stage_if
// Bundles the EX-to-WB pipeline signals and the register-file write-back
// port of the write-back stage.
//
//   EX side (driven by the master, read by the stage):
//     RW        register-write enable
//     DA        destination register address
//     MD        write-back source select
//     MW        data-memory write enable
//     F         ALU/shifter result, also the data-memory address
//     Data_Out  store data
//     VxorN     set-less-than flag
//     HOLD      stall the stage and suppress the store
//     FLUSH     squash the stage into a bubble
//   Write-back side (driven by the stage):
//     RF_WE     register-file write enable
//     RF_WA     register-file write address
//     BUS_D     register-file write data
//     RETIRED   count of committed register writes
// ---------------------------------------------------------------------------
interface wb_stage_if;
    logic        RW;
    logic [4:0]  DA;
    logic [1:0]  MD;
    logic        MW;
    logic [31:0] F;
    logic [31:0] Data_Out;
    logic        VxorN;
    logic        HOLD;
    logic        FLUSH;
    logic        RF_WE;
    logic [4:0]  RF_WA;
    logic [31:0] BUS_D;
    logic [31:0] RETIRED;

    modport master (
        output RW, DA, MD, MW, F, Data_Out, VxorN, HOLD, FLUSH,
        input  RF_WE, RF_WA, BUS_D, RETIRED
    );

    modport slave (
        input  RW, DA, MD, MW, F, Data_Out, VxorN, HOLD, FLUSH,
        output RF_WE, RF_WA, BUS_D, RETIRED
    );
endinterface

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage
// Memory / write-back pipeline stage. Holds a 256x32 data memory addressed
// by F[7:0], a stage register capturing the EX instruction, the write-back
// mux feeding the register file, and a counter of committed register writes.
//
//   CLOCK   rising-edge clock
//   RESET   asynchronous active-low reset (memory contents are kept)
//   bus     wb_stage_if.slave: EX inputs, HOLD/FLUSH, register-file outputs
// ---------------------------------------------------------------------------
module wb_stage (
    input logic      CLOCK,
    input logic      RESET,
    wb_stage_if.slave bus
);

    logic [31:0] mem [256];

    logic        rw_q, rw_d;
    logic [4:0]  da_q, da_d;
    logic [1:0]  md_q, md_d;
    logic [31:0] f_q, f_d;
    logic        v_q, v_d;
    logic [31:0] m_q, m_d;
    logic [31:0] retired_q, retired_d;

    logic [7:0]  memAddr;
    logic        capture;
    logic        retire;

    // Upper address bits are ignored so addresses wrap modulo 256.
    assign memAddr = bus.F[7:0];
    assign capture = !bus.HOLD && !bus.FLUSH;
    assign retire  = capture && bus.RW && (bus.DA != 5'd0);

    // Data memory: no reset, and a store is dropped whenever the stage is
    // stalled, squashed or held in reset at the edge.
    always_ff @(posedge CLOCK) begin
        if (RESET && capture && bus.MW) begin
            mem[memAddr] <= bus.Data_Out;
        end
    end

    // Next-state of the stage register. FLUSH takes priority over HOLD;
    // the memory read returns the contents before any same-edge store.
    always_comb begin
        rw_d      = rw_q;
        da_d      = da_q;
        md_d      = md_q;
        f_d       = f_q;
        v_d       = v_q;
        m_d       = m_q;
        retired_d = retired_q;
        if (bus.FLUSH) begin
            rw_d = 1'b0;
            da_d = 5'd0;
            md_d = 2'b00;
            f_d  = 32'd0;
            v_d  = 1'b0;
        end else if (!bus.HOLD) begin
            rw_d = bus.RW;
            da_d = bus.DA;
            md_d = bus.MD;
            f_d  = bus.F;
            v_d  = bus.VxorN;
            m_d  = mem[memAddr];
        end
        if (retire) begin
            retired_d = retired_q + 32'd1;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            rw_q      <= 1'b0;
            da_q      <= 5'd0;
            md_q      <= 2'b00;
            f_q       <= 32'd0;
            v_q       <= 1'b0;
            m_q       <= 32'd0;
            retired_q <= 32'd0;
        end else begin
            rw_q      <= rw_d;
            da_q      <= da_d;
            md_q      <= md_d;
            f_q       <= f_d;
            v_q       <= v_d;
            m_q       <= m_d;
            retired_q <= retired_d;
        end
    end

    // Write-back source select; code 11 is reserved and behaves like 00.
    always_comb begin
        bus.BUS_D = f_q;
        case (md_q)
            2'b01:   bus.BUS_D = m_q;
            2'b10:   bus.BUS_D = {31'b0, v_q};
            default: bus.BUS_D = f_q;
        endcase
    end

    // R0 is hard-wired, so a write to it is never enabled.
    assign bus.RF_WE   = rw_q && (da_q != 5'd0);
    assign bus.RF_WA   = da_q;
    assign bus.RETIRED = retired_q;

endmodule
